// File: rtl/cbc_sequencer_pkg.sv
// cbc_sequencer_pkg: shared widths, types and whitening helper for the CBC sequencer.
// Rev 1.0
`default_nettype none

package cbc_sequencer_pkg;

  localparam int BLK_S   = 128;
  localparam int IV_BITS = 128;
  localparam int CNT_W   = 16;

  typedef logic [BLK_S-1:0]   blk_t;
  typedef logic [IV_BITS-1:0] iv_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  typedef enum logic {
    MODE_DEC = 1'b0,
    MODE_ENC = 1'b1
  } mode_e;

  // The chaining XOR; BLK_S and IV_BITS must match for this to be well formed.
  function automatic blk_t whiten(input blk_t data, input iv_t iv);
    return data ^ iv;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cbc_sequencer_if.sv
// cbc_sequencer_if: input stream, output stream and AES core handshake bundle.
// Rev 1.0
`default_nettype none

interface cbc_sequencer_if;
  import cbc_sequencer_pkg::*;

  logic s_valid;
  logic s_ready;
  blk_t s_data;
  logic s_last;

  logic m_valid;
  logic m_ready;
  blk_t m_data;
  logic m_last;

  logic core_start;
  blk_t core_blk;
  logic core_done;
  blk_t core_result;

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready,
    output m_valid, m_data, m_last,
    input  m_ready,
    output core_start, core_blk,
    input  core_done, core_result
  );

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready,
    input  m_valid, m_data, m_last,
    output m_ready,
    input  core_start, core_blk,
    output core_done, core_result
  );

endinterface

`default_nettype wire

// File: rtl/cbc_xor_mix.sv
// cbc_xor_mix: mode-dependent chaining datapath (core input, chained output, next IV).
// Rev 1.0
`default_nettype none

module cbc_xor_mix
  import cbc_sequencer_pkg::*;
(
  input  mode_e mode,
  input  blk_t  s_data,
  input  iv_t   iv,
  input  blk_t  in_reg,
  input  blk_t  core_result,
  output blk_t  core_blk,
  output blk_t  m_data,
  output iv_t   iv_next
);

  always_comb begin
    core_blk = s_data;
    m_data   = whiten(core_result, iv);
    iv_next  = in_reg;
    // Encrypt whitens before the core and chains on ciphertext out of the core.
    if (mode == MODE_ENC) begin
      core_blk = whiten(s_data, iv);
      m_data   = core_result;
      iv_next  = core_result;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cbc_sequencer.sv
// cbc_sequencer: holds the CBC IV, whitens blocks around a single-in-flight AES core.
// Rev 1.0
`default_nettype none

module cbc_sequencer
  import cbc_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               iv_load,
  input  iv_t                iv_in,
  input  logic               encryption,
  cbc_sequencer_if.slave     bus,
  output cnt_t               blk_cnt,
  output logic               busy,
  output logic               err_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    CORE  = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t state, state_nxt;

  iv_t   iv, iv_nxt;
  mode_e mode, mode_nxt;
  blk_t  in_reg, in_reg_nxt;
  blk_t  core_blk, core_blk_nxt;
  blk_t  m_data, m_data_nxt;
  logic  last_pend, last_pend_nxt;
  logic  m_last, m_last_nxt;
  logic  m_valid, m_valid_nxt;
  logic  core_start, core_start_nxt;
  logic  busy_nxt;
  logic  err_nxt;
  cnt_t  blk_cnt_nxt;

  blk_t  mix_core_blk;
  blk_t  mix_m_data;
  iv_t   mix_iv;
  logic  done_ok;

  cbc_xor_mix u_mix (
    .mode        (mode),
    .s_data      (bus.s_data),
    .iv          (iv),
    .in_reg      (in_reg),
    .core_result (bus.core_result),
    .core_blk    (mix_core_blk),
    .m_data      (mix_m_data),
    .iv_next     (mix_iv)
  );

  assign bus.s_ready    = (state == READY) && !iv_load;
  assign bus.m_valid    = m_valid;
  assign bus.m_data     = m_data;
  assign bus.m_last     = m_last;
  assign bus.core_start = core_start;
  assign bus.core_blk   = core_blk;

  // A done coinciding with core_start cannot belong to this block; the core needs latency >= 1.
  assign done_ok = (state == CORE) && bus.core_done && !core_start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    iv_nxt         = iv;
    mode_nxt       = mode;
    in_reg_nxt     = in_reg;
    core_blk_nxt   = core_blk;
    m_data_nxt     = m_data;
    last_pend_nxt  = last_pend;
    m_last_nxt     = m_last;
    m_valid_nxt    = m_valid;
    core_start_nxt = 1'b0;
    blk_cnt_nxt    = blk_cnt;
    err_nxt        = err_done | (bus.core_done && (state != CORE));

    case (state)
      IDLE: begin
        if (iv_load) begin
          iv_nxt      = iv_in;
          mode_nxt    = mode_e'(encryption);
          blk_cnt_nxt = '0;
          state_nxt   = READY;
        end
      end

      READY: begin
        if (iv_load) begin
          iv_nxt      = iv_in;
          mode_nxt    = mode_e'(encryption);
          blk_cnt_nxt = '0;
        end else if (bus.s_valid) begin
          in_reg_nxt     = bus.s_data;
          last_pend_nxt  = bus.s_last;
          core_blk_nxt   = mix_core_blk;
          core_start_nxt = 1'b1;
          state_nxt      = CORE;
        end
      end

      CORE: begin
        if (done_ok) begin
          m_data_nxt  = mix_m_data;
          iv_nxt      = mix_iv;
          m_last_nxt  = last_pend;
          m_valid_nxt = 1'b1;
          blk_cnt_nxt = blk_cnt + cnt_t'(1);
          state_nxt   = OUT;
        end
      end

      OUT: begin
        if (bus.m_ready) begin
          m_valid_nxt = 1'b0;
          state_nxt   = m_last ? IDLE : READY;
        end
      end

      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt == CORE) || (state_nxt == OUT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iv         <= '0;
      mode       <= MODE_DEC;
      in_reg     <= '0;
      core_blk   <= '0;
      m_data     <= '0;
      last_pend  <= 1'b0;
      m_last     <= 1'b0;
      m_valid    <= 1'b0;
      core_start <= 1'b0;
      blk_cnt    <= '0;
      busy       <= 1'b0;
      err_done   <= 1'b0;
    end else begin
      iv         <= iv_nxt;
      mode       <= mode_nxt;
      in_reg     <= in_reg_nxt;
      core_blk   <= core_blk_nxt;
      m_data     <= m_data_nxt;
      last_pend  <= last_pend_nxt;
      m_last     <= m_last_nxt;
      m_valid    <= m_valid_nxt;
      core_start <= core_start_nxt;
      blk_cnt    <= blk_cnt_nxt;
      busy       <= busy_nxt;
      err_done   <= err_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cbc_sequencer.sv
// tb_cbc_sequencer: randomized CBC stream against a queue-based reference, with inverting core model.
// Rev 1.0
`default_nettype none

module tb_cbc_sequencer;
  import cbc_sequencer_pkg::*;

  localparam int L = 3;

  typedef struct packed {
    blk_t        data;
    logic        last;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        iv_load;
  iv_t         iv_in;
  logic        encryption;
  logic [15:0] blk_cnt;
  logic        busy;
  logic        err_done;

  cbc_sequencer_if bus();

  cbc_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .iv_load    (iv_load),
    .iv_in      (iv_in),
    .encryption (encryption),
    .bus        (bus.slave),
    .blk_cnt    (blk_cnt),
    .busy       (busy),
    .err_done   (err_done)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int cs_count = 0;
  int mr_mode = 0;

  exp_t out_q[$];
  blk_t cb_q[$];

  logic        mdl_enc;
  blk_t        mdl_iv;
  logic [15:0] mdl_cnt;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic timeout_fail(input string nm);
    n_total++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  function automatic blk_t rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference cipher is bitwise inversion, so it is its own inverse.
  function automatic blk_t cipher_e(input blk_t x);
    return ~x;
  endfunction

  function automatic blk_t cipher_d(input blk_t x);
    return ~x;
  endfunction

  // CBC: C_i = E(P_i ^ C_{i-1}); P_i = D(C_i) ^ C_{i-1}.
  task automatic model_block(input blk_t d, input logic last);
    exp_t e;
    if (mdl_enc) begin
      cb_q.push_back(d ^ mdl_iv);
      e.data = cipher_e(d ^ mdl_iv);
      mdl_iv = e.data;
    end else begin
      cb_q.push_back(d);
      e.data = cipher_d(d) ^ mdl_iv;
      mdl_iv = d;
    end
    mdl_cnt = mdl_cnt + 16'd1;
    e.last  = last;
    e.cnt   = mdl_cnt;
    out_q.push_back(e);
  endtask

  // Core model: fixed latency L, result = ~core_blk.
  blk_t core_cap;
  initial begin
    bus.core_done   = 1'b0;
    bus.core_result = '0;
    forever begin
      @(negedge clk);
      if (bus.core_start === 1'b1) begin
        core_cap = bus.core_blk;
        if (cb_q.size() == 0) timeout_fail("core_blk_unexpected_start");
        else chk("core_blk", core_cap, cb_q.pop_front());
        repeat (L) @(posedge clk);
        #1;
        bus.core_done   = 1'b1;
        bus.core_result = ~core_cap;
        @(posedge clk);
        #1;
        bus.core_done   = 1'b0;
      end
    end
  end

  always @(negedge clk) if (bus.core_start === 1'b1) cs_count++;

  exp_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
        if (out_q.size() == 0) begin
          timeout_fail("m_valid_unexpected");
        end else begin
          mon_e = out_q.pop_front();
          chk("m_data", bus.m_data, mon_e.data);
          chk("m_last", bus.m_last, mon_e.last);
          chk("blk_cnt_at_out", blk_cnt, mon_e.cnt);
        end
      end
    end
  end

  initial begin
    bus.m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (mr_mode)
        0:       bus.m_ready = 1'b1;
        1:       bus.m_ready = 1'($urandom_range(0, 1));
        default: bus.m_ready = 1'b0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_iv(input logic enc, input blk_t iv);
    iv_load    = 1'b1;
    iv_in      = iv;
    encryption = enc;
    tick();
    iv_load = 1'b0;
    mdl_enc = enc;
    mdl_iv  = iv;
    mdl_cnt = 16'd0;
  endtask

  task automatic send_block(input blk_t d, input logic last);
    int i;
    model_block(d, last);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.s_ready === 1'b1) break;
    end
    if (i == 300) timeout_fail("s_ready_wait");
    tick();
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_quiet();
    int i;
    for (i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && bus.m_valid === 1'b0 && out_q.size() == 0) break;
    end
    if (i == 400) timeout_fail("quiet_wait");
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  blk_t r_iv, r_d;
  int   cs0;
  int   nb;

  initial begin
    reset       = 1'b0;
    iv_load     = 1'b0;
    iv_in       = '0;
    encryption  = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    mdl_enc     = 1'b0;
    mdl_iv      = '0;
    mdl_cnt     = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    @(negedge clk);
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_core_start", bus.core_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_done", err_done, 0);
    chk("rst_blk_cnt", blk_cnt, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_core_blk", bus.core_blk, 0);
    chk("rst_m_last", bus.m_last, 0);
    tick();

    // Directed encrypt then decrypt of the same two-block message.
    load_iv(1'b1, '0);
    send_block(128'd1, 1'b0);
    send_block(128'd2, 1'b1);
    wait_quiet();
    chk("enc_blk_cnt", blk_cnt, 2);
    chk("enc_idle_s_ready", bus.s_ready, 0);
    chk("enc_busy", busy, 0);

    load_iv(1'b0, '0);
    r_d = 128'd1;
    send_block(~r_d, 1'b0);
    send_block(128'd3, 1'b1);
    wait_quiet();
    chk("dec_blk_cnt", blk_cnt, 2);

    // Backpressure: output must hold with no further core activity.
    load_iv(1'b1, rnd128());
    mr_mode = 2;
    cs0 = cs_count;
    send_block(rnd128(), 1'b1);
    begin
      int i;
      for (i = 0; i < 50; i++) begin
        @(negedge clk);
        if (bus.m_valid === 1'b1) break;
      end
      if (i == 50) timeout_fail("bp_m_valid_wait");
    end
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_m_data_hold", bus.m_data, out_q[0].data);
      chk("bp_m_valid_hold", bus.m_valid, 1);
      chk("bp_s_ready_low", bus.s_ready, 0);
    end
    chk("bp_core_start_count", cs_count - cs0, 1);
    mr_mode = 0;
    wait_quiet();

    // iv_load and s_valid together in READY: iv_load wins.
    load_iv(1'b1, rnd128());
    send_block(rnd128(), 1'b0);
    wait_quiet();
    r_iv = rnd128();
    r_d  = rnd128();
    iv_load     = 1'b1;
    iv_in       = r_iv;
    encryption  = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = r_d;
    bus.s_last  = 1'b1;
    @(negedge clk);
    chk("collide_s_ready", bus.s_ready, 0);
    tick();
    iv_load = 1'b0;
    mdl_enc = 1'b0;
    mdl_iv  = r_iv;
    mdl_cnt = 16'd0;
    send_block(r_d, 1'b1);
    wait_quiet();
    chk("collide_blk_cnt", blk_cnt, 1);

    // Reset while the core is working; its late done must flag err_done.
    load_iv(1'b1, rnd128());
    send_block(rnd128(), 1'b1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_core_start", bus.core_start, 0);
    chk("midrst_core_blk", bus.core_blk, 0);
    chk("midrst_m_valid", bus.m_valid, 0);
    chk("midrst_m_data", bus.m_data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_blk_cnt", blk_cnt, 0);
    chk("midrst_err_done", err_done, 0);
    out_q.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    begin
      int i;
      for (i = 0; i < 20; i++) begin
        @(negedge clk);
        if (err_done === 1'b1) break;
      end
      chk("midrst_err_done_set", err_done, 1);
    end
    chk("midrst_no_output", bus.m_valid, 0);
    repeat (3) tick();
    chk("err_done_sticky", err_done, 1);

    // Counter wrap from 0xFFFF.
    load_iv(1'b1, rnd128());
    @(negedge clk);
    force dut.blk_cnt = 16'hFFFF;
    tick();
    release dut.blk_cnt;
    mdl_cnt = 16'hFFFF;
    send_block(rnd128(), 1'b1);
    wait_quiet();
    chk("wrap_blk_cnt", blk_cnt, 0);

    // Randomized messages with random output backpressure.
    mr_mode = 1;
    for (int m = 0; m < 8; m++) begin
      load_iv(1'($urandom_range(0, 1)), rnd128());
      nb = int'($urandom_range(1, 5));
      for (int b = 0; b < nb; b++) send_block(rnd128(), b == nb - 1);
      wait_quiet();
      chk("rand_blk_cnt", blk_cnt, 16'(nb));
    end
    mr_mode = 0;

    chk("out_q_drained", out_q.size(), 0);
    chk("cb_q_drained", cb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
